// File: rtl/lt24_stream_ctrl_if.sv
// rtl/lt24_stream_ctrl_if.sv - Avalon-MM register port bundle for the LT24 write engine
// master drives the bus (host side), slave is the controller.
interface lt24_stream_ctrl_if;
  logic [1:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;

  modport master (
    output avs_address, avs_write, avs_writedata, avs_read,
    input  avs_readdata, avs_waitrequest
  );

  modport slave (
    input  avs_address, avs_write, avs_writedata, avs_read,
    output avs_readdata, avs_waitrequest
  );
endinterface

// File: rtl/lt24_stream_ctrl.sv
// rtl/lt24_stream_ctrl.sv - 8080-style LT24 write engine with command FIFO and pixel fill repeat
// FIFO entries carry {rs, repeat count, data}; the strobe FSM replays one entry count times.
module lt24_stream_ctrl #(
  parameter int DATA_W      = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int CNT_W       = 17,
  parameter int WR_LOW_CYC  = 2,
  parameter int WR_HIGH_CYC = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  lt24_stream_ctrl_if.slave avs,
  output logic              lt24_cs_n,
  output logic              lt24_rs,
  output logic              lt24_wr_n,
  output logic              lt24_rd_n,
  output logic [DATA_W-1:0] lt24_data
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int EW      = 1 + CNT_W + DATA_W;
  localparam int CYC_MAX = (WR_LOW_CYC > WR_HIGH_CYC) ? WR_LOW_CYC : WR_HIGH_CYC;
  localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
  localparam logic [CYC_W-1:0] LO_LAST = CYC_W'(WR_LOW_CYC - 1);
  localparam logic [CYC_W-1:0] HI_LAST = CYC_W'(WR_HIGH_CYC - 1);
  localparam logic [AW:0]      LVL_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WR_LO, S_WR_HI} state_t;

  state_t             state_q, state_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic               cur_rs_q, cur_rs_d;
  logic [DATA_W-1:0]  cur_data_q, cur_data_d;
  logic [CNT_W-1:0]   cnt_reg_q, cnt_reg_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]        level_q, level_d;
  logic [31:0]        readdata_q, readdata_d;
  logic               cs_n_q, cs_n_d, wr_n_q, wr_n_d, rs_q, rs_d;
  logic [DATA_W-1:0]  data_q, data_d;

  logic [EW-1:0]      fifo_mem [FIFO_DEPTH];
  logic [EW-1:0]      head, push_entry;
  logic               head_rs;
  logic [CNT_W-1:0]   head_cnt, fill_cnt;
  logic [DATA_W-1:0]  head_data;
  logic               fifo_full, fifo_empty, push_addr, push, pop;
  logic [31:0]        status;
  logic               unused_wd;

  assign unused_wd  = ^avs.avs_writedata;
  assign fifo_full  = (level_q == LVL_FULL);
  assign fifo_empty = (level_q == '0);
  assign push_addr  = (avs.avs_address != 2'd2);

  // A pop in the same cycle frees the slot, so a write against a full FIFO lands immediately.
  assign push = avs.avs_write & push_addr & (~fifo_full | pop);
  assign avs.avs_waitrequest = avs.avs_write & push_addr & fifo_full & ~pop;

  assign fill_cnt   = (cnt_reg_q == '0) ? CNT_W'(1) : cnt_reg_q;
  assign push_entry = {avs.avs_address != 2'd0,
                       (avs.avs_address == 2'd3) ? fill_cnt : CNT_W'(1),
                       avs.avs_writedata[DATA_W-1:0]};

  assign head      = fifo_mem[rd_ptr_q];
  assign head_rs   = head[EW-1];
  assign head_cnt  = head[DATA_W +: CNT_W];
  assign head_data = head[DATA_W-1:0];

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    rem_d      = rem_q;
    cur_rs_d   = cur_rs_q;
    cur_data_d = cur_data_q;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          cur_rs_d   = head_rs;
          cur_data_d = head_data;
          rem_d      = head_cnt - CNT_W'(1);
          state_d    = S_SETUP;
        end
      end
      S_SETUP: begin
        cyc_d   = '0;
        state_d = S_WR_LO;
      end
      S_WR_LO: begin
        if (cyc_q == LO_LAST) begin
          cyc_d   = '0;
          state_d = S_WR_HI;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      S_WR_HI: begin
        if (cyc_q == HI_LAST) begin
          cyc_d = '0;
          if (rem_q != '0) begin
            rem_d   = rem_q - CNT_W'(1);
            state_d = S_WR_LO;
          end else if (!fifo_empty) begin
            pop        = 1'b1;
            cur_rs_d   = head_rs;
            cur_data_d = head_data;
            rem_d      = head_cnt - CNT_W'(1);
            state_d    = S_SETUP;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d   = level_q;
    if (push && !pop) level_d = level_q + (AW + 1)'(1);
    if (!push && pop) level_d = level_q - (AW + 1)'(1);
    cnt_reg_d = (avs.avs_write && avs.avs_address == 2'd2) ? avs.avs_writedata[CNT_W-1:0]
                                                           : cnt_reg_q;
    status         = '0;
    status[31]     = (state_q != S_IDLE) | ~fifo_empty;
    status[30]     = fifo_full;
    status[AW:0]   = level_q;
    readdata_d     = avs.avs_read ? status : readdata_q;
  end

  // Pins are registered from the current state, so rs/data only move on the cycle SETUP is shown.
  always_comb begin
    cs_n_d = (state_q == S_IDLE);
    wr_n_d = (state_q != S_WR_LO);
    rs_d   = (state_q == S_SETUP) ? cur_rs_q   : rs_q;
    data_d = (state_q == S_SETUP) ? cur_data_q : data_q;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= push_entry;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cyc_q      <= '0;
      rem_q      <= '0;
      cur_rs_q   <= 1'b0;
      cur_data_q <= '0;
      cnt_reg_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      readdata_q <= '0;
      cs_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      rs_q       <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      rem_q      <= rem_d;
      cur_rs_q   <= cur_rs_d;
      cur_data_q <= cur_data_d;
      cnt_reg_q  <= cnt_reg_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      readdata_q <= readdata_d;
      cs_n_q     <= cs_n_d;
      wr_n_q     <= wr_n_d;
      rs_q       <= rs_d;
      data_q     <= data_d;
    end
  end

  assign avs.avs_readdata = readdata_q;
  assign lt24_cs_n        = cs_n_q;
  assign lt24_wr_n        = wr_n_q;
  assign lt24_rs          = rs_q;
  assign lt24_data        = data_q;
  assign lt24_rd_n        = 1'b1;

endmodule

// File: tb/tb_lt24_stream_ctrl.sv
// tb/tb_lt24_stream_ctrl.sv - scoreboard bench for lt24_stream_ctrl
// Writes push expected strobes; a forked monitor pops one per wr_n rising edge.
module tb_lt24_stream_ctrl;
  localparam int DATA_W = 16, FIFO_DEPTH = 16, CNT_W = 17, WR_LOW_CYC = 2, WR_HIGH_CYC = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              lt24_cs_n, lt24_rs, lt24_wr_n, lt24_rd_n;
  logic [DATA_W-1:0] lt24_data;

  lt24_stream_ctrl_if avs();

  lt24_stream_ctrl #(
    .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W),
    .WR_LOW_CYC(WR_LOW_CYC), .WR_HIGH_CYC(WR_HIGH_CYC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .avs(avs),
    .lt24_cs_n(lt24_cs_n), .lt24_rs(lt24_rs), .lt24_wr_n(lt24_wr_n),
    .lt24_rd_n(lt24_rd_n), .lt24_data(lt24_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        rs;
    logic [15:0] data;
    logic [7:0]  gap;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0, failures = 0;
  int         fall_cnt = 0, rise_cnt = 0, cs_rise_cnt = 0;
  logic [16:0] cnt_model = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic prev_wr = 1'b1;
    logic prev_cs = 1'b1;
    int   fall_c = 0, prev_fall_c = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_wr = 1'b1;
        prev_cs = 1'b1;
      end else begin
        if (!prev_cs && lt24_cs_n) cs_rise_cnt++;
        if (prev_wr && !lt24_wr_n) begin
          prev_fall_c = fall_c;
          fall_c      = cyc;
          fall_cnt++;
        end else if (!prev_wr && lt24_wr_n) begin
          rise_cnt++;
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_strobe actual rs=%0d data=%0h required none", lt24_rs, lt24_data);
          end else begin
            e = sb.pop_front();
            chk("strobe", {lt24_cs_n, lt24_rs, lt24_data, 8'(cyc - fall_c)},
                {1'b0, e.rs, e.data, 8'(WR_LOW_CYC)});
            if (e.gap != 0) chk("strobe_gap", 8'(fall_c - prev_fall_c), e.gap);
          end
        end
        prev_wr = lt24_wr_n;
        prev_cs = lt24_cs_n;
      end
    end
  endtask

  task automatic push_exp(input logic rs, input logic [15:0] d, input logic [7:0] g);
    exp_t e;
    e.rs = rs; e.data = d; e.gap = g;
    sb.push_back(e);
  endtask

  task automatic avs_wr(input logic [1:0] a, input logic [31:0] wd, input logic [7:0] g0,
                        output int stalls);
    bit acc = 1'b0;
    int n;
    stalls = 0;
    @(posedge clk); #1;
    avs.avs_address = a; avs.avs_write = 1'b1; avs.avs_writedata = wd;
    for (int i = 0; i < 400 && !acc; i++) begin
      @(negedge clk);
      if (!avs.avs_waitrequest) acc = 1'b1;
      else stalls++;
      @(posedge clk);
    end
    #1 avs.avs_write = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL write_timeout actual=stalled required=accepted addr=%0d", a);
    end else begin
      case (a)
        2'd0: push_exp(1'b0, wd[15:0], g0);
        2'd1: push_exp(1'b1, wd[15:0], g0);
        2'd2: cnt_model = wd[16:0];
        default: begin
          n = (cnt_model == 0) ? 1 : int'(cnt_model);
          for (int k = 0; k < n; k++) push_exp(1'b1, wd[15:0], (k == 0) ? g0 : 8'd4);
        end
      endcase
    end
  endtask

  task automatic avs_rd(output logic [31:0] v);
    @(posedge clk); #1 avs.avs_read = 1'b1;
    @(posedge clk); #1 avs.avs_read = 1'b0;
    v = avs.avs_readdata;
  endtask

  task automatic wait_idle();
    logic [31:0] v;
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      avs_rd(v);
      if (!v[31]) done = 1'b1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    logic [31:0] v;
    logic [8:0]  cs_pat, wr_pat;
    int          st, r0, c0, f0;
    bit          found;

    avs.avs_address = '0; avs.avs_write = 1'b0; avs.avs_writedata = '0; avs.avs_read = 1'b0;
    fork monitor(); join_none

    #3 reset_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      avs.avs_write     = 1'($urandom_range(0, 1));
      avs.avs_address   = 2'($urandom_range(0, 3));
      avs.avs_writedata = $urandom;
      avs.avs_read      = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("reset_outputs", {lt24_cs_n, lt24_wr_n, lt24_rd_n, lt24_rs, lt24_data}, {4'b1110, 16'h0000});
    end
    chk("reset_readdata", avs.avs_readdata, 32'h0);
    @(posedge clk); #1;
    avs.avs_write = 1'b0; avs.avs_read = 1'b0; avs.avs_writedata = '0;
    #2 reset_n = 1'b1;
    avs_rd(v);
    chk("status_after_reset", v, 32'h0);

    // Single command: exact cs_n / wr_n waveform relative to the accepting edge.
    avs_wr(2'd0, 32'h0000_002C, 8'd0, st);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      cs_pat[k] = lt24_cs_n;
      wr_pat[k] = lt24_wr_n;
    end
    chk("cmd_cs_n_wave", cs_pat, 9'b110000011);
    chk("cmd_wr_n_wave", wr_pat, 9'b111100111);
    avs_rd(v);
    chk("cmd_status_idle", v, 32'h0);

    // Long fill keeps the engine busy while the FIFO is filled to the top.
    c0 = cs_rise_cnt;
    avs_wr(2'd2, 32'd20, 8'd0, st);
    avs_wr(2'd3, 32'h0000_ABCD, 8'd0, st);
    for (int i = 0; i < 16; i++) avs_wr(2'd1, 32'h1000 + i, 8'd5, st);
    avs_rd(v);
    chk("status_full_peak", v, 32'hC000_0010);
    avs_wr(2'd1, 32'h0000_1010, 8'd5, st);
    chk("extra_write_stalled", (st > 0), 1);
    avs_rd(v);
    chk("status_push_pop_at_full", v, 32'hC000_0010);
    wait_idle();
    chk("burst_cs_single_rise", cs_rise_cnt - c0, 1);
    chk("burst_drained", sb.size(), 0);

    // Fill counts travel with their entries.
    avs_wr(2'd2, 32'd5, 8'd0, st);
    avs_wr(2'd3, 32'h0000_F800, 8'd0, st);
    avs_wr(2'd3, 32'h0000_07E0, 8'd5, st);
    avs_wr(2'd2, 32'd2, 8'd0, st);
    avs_wr(2'd3, 32'h0000_001F, 8'd5, st);
    wait_idle();
    chk("fill_drained", sb.size(), 0);
    r0 = rise_cnt;
    avs_wr(2'd2, 32'd0, 8'd0, st);
    avs_wr(2'd3, 32'h0000_1234, 8'd0, st);
    wait_idle();
    chk("fill_count0_single", rise_cnt - r0, 1);

    avs_wr(2'd2, 32'd8, 8'd0, st);
    avs_wr(2'd3, 32'h0000_0F0F, 8'd0, st);
    for (int i = 0; i < 3; i++) avs_wr(2'd1, 32'h2000 + i, 8'd5, st);
    avs_rd(v);
    chk("status_level3", v, 32'h8000_0003);
    wait_idle();

    // Reset in the middle of the third strobe of a 10-pixel fill.
    r0 = rise_cnt;
    avs_wr(2'd2, 32'd10, 8'd0, st);
    avs_wr(2'd3, 32'h0000_AAAA, 8'd0, st);
    f0 = fall_cnt - 0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk); #1;
      if (fall_cnt >= f0 + 3) found = 1'b1;
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL third_strobe_timeout actual=%0d required=%0d", fall_cnt - f0, 3);
    end
    #1 reset_n = 1'b0;
    #1 chk("async_reset_outputs", {lt24_cs_n, lt24_wr_n, lt24_rd_n, lt24_rs, lt24_data},
           {4'b1110, 16'h0000});
    chk("strobes_before_reset", rise_cnt - r0, 2);
    sb.delete();
    cnt_model = '0;
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    r0 = rise_cnt;
    repeat (40) @(posedge clk);
    chk("no_resume_after_reset", rise_cnt - r0, 0);
    avs_rd(v);
    chk("status_after_mid_reset", v, 32'h0);
    avs_wr(2'd3, 32'h0000_5555, 8'd0, st);
    avs_wr(2'd0, 32'h0000_0029, 8'd5, st);
    wait_idle();
    chk("post_reset_strobes", rise_cnt - r0, 2);
    chk("final_drained", sb.size(), 0);
    avs_rd(v);
    chk("final_status", v, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
